// File: rtl/hgcal_input_quantizer.sv
// Serial charge quantizer for the HGCAL autoencoder front end: 2-bit codes per sample,
// packed into one frame per N_INPUTS samples, with a one-frame output buffer and error resync.
module hgcal_input_quantizer #(
  parameter int unsigned N_INPUTS = 48,
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned TH1      = 16,
  parameter int unsigned TH2      = 64,
  parameter int unsigned TH3      = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_WIDTH-1:0]   s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*N_INPUTS-1:0] m_data,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam int unsigned IdxW  = $clog2(N_INPUTS);
  localparam int unsigned DataW = 2 * N_INPUTS;
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(N_INPUTS - 1);
  localparam logic [IN_WIDTH-1:0] Th1     = IN_WIDTH'(TH1);
  localparam logic [IN_WIDTH-1:0] Th2     = IN_WIDTH'(TH2);
  localparam logic [IN_WIDTH-1:0] Th3     = IN_WIDTH'(TH3);

  typedef enum logic [0:0] {
    StCollect,
    StDiscard
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IdxW-1:0]   r_idx;
  logic [IdxW-1:0]   w_idx_nxt;
  // Holds slots 0..N-2 only; the final slot comes straight from the current sample.
  logic [DataW-3:0]  r_asm;
  logic              r_m_valid;
  logic [DataW-1:0]  r_m_data;
  logic              r_frame_err;
  logic [7:0]        r_err_count;

  logic              w_ge1;
  logic              w_ge2;
  logic              w_ge3;
  logic [1:0]        w_code;
  logic              w_out_free;
  logic              w_at_last;
  logic              w_accept;
  logic              w_load;
  logic              w_err;
  logic [DataW-1:0]  w_frame;

  assign w_ge1  = (s_data >= Th1);
  assign w_ge2  = (s_data >= Th2);
  assign w_ge3  = (s_data >= Th3);
  assign w_code = {1'b0, w_ge1} + {1'b0, w_ge2} + {1'b0, w_ge3};

  assign w_out_free = !r_m_valid || m_ready;
  assign w_at_last  = (r_state == StCollect) && (r_idx == LastIdx);
  assign s_ready    = w_at_last ? w_out_free : 1'b1;
  assign w_accept   = s_valid && s_ready;
  assign w_frame    = {w_code, r_asm};

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_err       = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        StCollect: begin
          if (w_at_last) begin
            w_load    = 1'b1;
            w_idx_nxt = '0;
            if (!s_last) begin
              w_err       = 1'b1;
              w_state_nxt = StDiscard;
            end
          end else if (s_last) begin
            w_err     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
        StDiscard: begin
          if (s_last) begin
            w_state_nxt = StCollect;
            w_idx_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = StCollect;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // Assembly slots need no reset: every slot is rewritten before a frame is emitted.
  always_ff @(posedge clk) begin
    if (w_accept && (r_state == StCollect) && !w_at_last) begin
      r_asm[{r_idx, 1'b0} +: 2] <= w_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StCollect;
      r_idx       <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame_err <= w_err;
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_frame;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Self-checking bench for hgcal_input_quantizer: a frame-level queue model checked every cycle,
// plus directed scenarios with hand-computed packed frames.
module tb_hgcal_input_quantizer;

  localparam int N  = 4;
  localparam int DW = 2 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'd0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          frame_err;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  hgcal_input_quantizer #(
    .N_INPUTS(N),
    .IN_WIDTH(8),
    .TH1(16),
    .TH2(64),
    .TH3(128)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .frame_err(frame_err),
    .err_count(err_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: list of codes of the frame in progress, discard flag, one-deep output.
  int            cur[$];
  bit            disc     = 1'b0;
  bit            ov       = 1'b0;
  logic [DW-1:0] od       = '0;
  bit            ee       = 1'b0;
  int            ec       = 0;
  bit            model_ok = 1'b0;
  logic [DW-1:0] got[$];

  function automatic int qz(input int v);
    int th[3] = '{16, 64, 128};
    int c = 0;
    foreach (th[i]) if (v >= th[i]) c++;
    return c;
  endfunction

  function automatic bit exp_ready();
    return disc || (cur.size() != N - 1) || !ov || m_ready;
  endfunction

  function automatic logic [DW-1:0] frame_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  task automatic model_step();
    bit            acc;
    bit            cons;
    bit            ld;
    bit            er;
    logic [DW-1:0] pk;
    if (rst) begin
      cur.delete();
      disc = 0; ov = 0; od = '0; ee = 0; ec = 0;
      model_ok = 1;
    end else if (model_ok) begin
      acc  = s_valid && exp_ready();
      cons = ov && m_ready;
      ld = 0; er = 0; pk = '0;
      if (acc) begin
        if (disc) begin
          if (s_last) disc = 0;
        end else begin
          cur.push_back(qz(int'(s_data)));
          if (cur.size() == N) begin
            for (int k = 0; k < N; k++) pk |= DW'(cur[k]) << (2 * k);
            ld = 1;
            if (!s_last) begin
              er = 1;
              disc = 1;
            end
            cur.delete();
          end else if (s_last) begin
            er = 1;
            cur.delete();
          end
        end
      end
      if (ld) begin
        ov = 1;
        od = pk;
      end else if (cons) begin
        ov = 0;
      end
      ee = er;
      if (er && ec < 255) ec++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("m_valid", 64'(m_valid), 64'(ov));
      if (ov) chk("m_data", 64'(m_data), 64'(od));
      chk("frame_err", 64'(frame_err), 64'(ee));
      chk("err_count", 64'(err_count), 64'(ec));
      chk("s_ready", 64'(s_ready), 64'(exp_ready()));
      if (!rst && m_valid && m_ready) got.push_back(m_data);
    end
  end

  task automatic send(input logic [7:0] d, input bit l);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: s_ready stuck at 0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    chk("reset_m_data", 64'(m_data), 64'd0);
    @(posedge clk);
    #1;

    // Quantization and packing: codes 0,1,2,3.
    got.delete();
    m_ready = 1'b1;
    send(8'd15, 0); send(8'd16, 0); send(8'd100, 0); send(8'd200, 1);
    @(negedge clk);
    chk("quant_latency_valid", 64'(m_valid), 64'd1);
    chk("quant_data", 64'(m_data), 64'hE4);
    idle(3);
    chk("quant_count", 64'(got.size()), 64'd1);

    // Backpressure: A = 3,2,1,0 -> 0x1B ; B = 2,2,3,0 -> 0x3A.
    do_reset();
    got.delete();
    m_ready = 1'b0;
    send(8'd200, 0); send(8'd100, 0); send(8'd16, 0); send(8'd0, 1);
    send(8'd64, 0); send(8'd64, 0); send(8'd128, 0);
    s_valid = 1'b1; s_data = 8'd15; s_last = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_low", 64'(s_ready), 64'd0);
    chk("bp_hold_valid", 64'(m_valid), 64'd1);
    chk("bp_hold_data", 64'(m_data), 64'h1B);
    repeat (2) @(negedge clk);
    chk("bp_hold_data_later", 64'(m_data), 64'h1B);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_high", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("bp_swap_valid", 64'(m_valid), 64'd1);
    chk("bp_swap_data", 64'(m_data), 64'h3A);
    idle(3);
    chk("bp_count", 64'(got.size()), 64'd2);
    chk("bp_first", 64'(frame_at(0)), 64'h1B);
    chk("bp_second", 64'(frame_at(1)), 64'h3A);

    // Streaming: 8 back-to-back frames.
    do_reset();
    got.delete();
    for (int f = 0; f < 8; f++)
      for (int k = 0; k < N; k++)
        send(8'((f * 37 + k * 61) % 256), k == N - 1);
    idle(3);
    chk("stream_count", 64'(got.size()), 64'd8);
    chk("stream_first", 64'(frame_at(0)), 64'hE4);

    // Short frame then a good one: 0,0,0,3 -> 0xC0.
    do_reset();
    got.delete();
    send(8'd10, 0); send(8'd20, 1);
    send(8'd0, 0); send(8'd0, 0); send(8'd0, 0); send(8'd255, 1);
    idle(3);
    chk("short_err_count", 64'(err_count), 64'd1);
    chk("short_count", 64'(got.size()), 64'd1);
    chk("short_data", 64'(frame_at(0)), 64'hC0);

    // Long frame: first four emitted, 5th and 6th dropped; then 3,3,0,0 -> 0x0F.
    do_reset();
    got.delete();
    send(8'd0, 0); send(8'd16, 0); send(8'd64, 0); send(8'd128, 0);
    send(8'd200, 0); send(8'd5, 1);
    send(8'd255, 0); send(8'd255, 0); send(8'd0, 0); send(8'd0, 1);
    idle(3);
    chk("long_err_count", 64'(err_count), 64'd1);
    chk("long_count", 64'(got.size()), 64'd2);
    chk("long_first", 64'(frame_at(0)), 64'hE4);
    chk("long_second", 64'(frame_at(1)), 64'h0F);

    // Reset mid-frame.
    do_reset();
    send(8'd50, 0); send(8'd60, 0);
    do_reset();
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    got.delete();
    send(8'd128, 0); send(8'd64, 0); send(8'd16, 0); send(8'd0, 1);
    idle(3);
    chk("midrst_count", 64'(got.size()), 64'd1);
    chk("midrst_data", 64'(frame_at(0)), 64'h1B);

    // err_count saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(8'd1, 0);
      send(8'd2, 1);
    end
    idle(2);
    chk("sat_err_count", 64'(err_count), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hgcal_input_quantizer.md
# hgcal_input_quantizer

Front-end stage of the HGCAL autoencoder pipeline that directly feeds the first neuron layer. Accepts a serial stream of unsigned trigger-cell charges, quantizes each charge to a 2-bit code against three thresholds, and packs one frame of N_INPUTS codes into the flat vector presented to layer 0. A valid/ready handshake on both sides provides a single-frame output buffer and backpressure. Malformed frames are detected, counted and resynchronised on the stream's end-of-frame marker.

## Interface
- N_INPUTS, 48: samples per frame; minimum 2.
- IN_WIDTH, 8: charge width in bits, unsigned.
- TH1, 16: lowest quantization threshold.
- TH2, 64: middle quantization threshold.
- TH3, 128: highest quantization threshold.
- Thresholds must satisfy TH1 < TH2 < TH3 < 2^IN_WIDTH.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  IN_WIDTH  charge value.
- s_last  in  1  marks the last sample of a frame.
- m_valid  out  1  packed frame valid.
- m_ready  in  1  layer 0 accepts the frame.
- m_data  out  2*N_INPUTS  packed codes; sample k occupies bits [2k+1:2k].
- frame_err  out  1  one-cycle pulse when a malformed frame is detected.
- err_count  out  8  count of malformed frames; saturates at 255.

## Operation
- **Quantization:** code = (s_data>=TH1) + (s_data>=TH2) + (s_data>=TH3), using unsigned compare. This gives 2'b00 through 2'b11.
- A sample is accepted when s_valid && s_ready.
- **out_free** = !m_valid || m_ready.
- **States:**
  - **COLLECT:** sample index idx runs from 0 to N_INPUTS-1. Each accepted sample writes its code into assembly slot idx.
    - If idx < N_INPUTS-1 and s_last=0: idx increments.
    - If idx < N_INPUTS-1 and s_last=1 (short frame): the frame is dropped, frame_err pulses, err_count increments, idx returns to 0, and the state stays COLLECT.
    - If idx = N_INPUTS-1: the completed frame (assembly contents plus the current code) loads into the output register, m_valid sets, and idx returns to 0.
      - If s_last=1, the state stays COLLECT.
      - If s_last=0 (long frame): the frame is still emitted, frame_err pulses, err_count increments, and the state becomes DISCARD.
  - **DISCARD:** s_ready=1. Accepted samples are dropped. An accepted sample with s_last=1 returns the state to COLLECT with idx=0. No additional errors are counted while in DISCARD.
- **s_ready:**
  - In COLLECT with idx = N_INPUTS-1: s_ready = out_free.
  - Otherwise: s_ready = 1.
  - s_ready never depends on s_valid or s_data.
- **Output register:**
  - m_valid clears on m_ready unless a new frame loads in the same cycle.
  - If a load and a consume happen in the same cycle, m_valid stays 1 and m_data takes the new frame.
  - m_data is held stable while m_valid && !m_ready.
- The assembly register is not cleared between frames. Every slot is overwritten before it is emitted.
- **Reset:** state=COLLECT, idx=0, m_valid=0, m_data=0, frame_err=0, err_count=0. s_ready is 1 in the cycle after reset.
  - Reset mid-frame discards the partial frame and any unconsumed output frame without raising an error.

## Timing
- Latency: the final sample accepted at edge t gives m_valid=1 with the frame's m_data after edge t, visible in cycle t+1.
- Throughput: one sample per cycle sustained. When the consumer always accepts, back-to-back frames complete every N_INPUTS cycles with no bubbles.
- Backpressure stalls only the final sample of a frame. Earlier samples of the next frame are accepted while the previous frame waits.
- frame_err is registered and is high for exactly the cycle after the offending sample is accepted.
- err_count updates on the same edge that frame_err is raised, and holds at 255.

## Test plan
Configuration for all tests: N_INPUTS=4, IN_WIDTH=8, TH1=16, TH2=64, TH3=128.
- **Quantization and packing:** frame 15, 16, 100, 200 with s_last on the 4th sample, m_ready=1 → m_data=8'b11_10_01_00 and m_valid high for one cycle, exactly one cycle after the 4th accept.
- **Backpressure:** hold m_ready=0 and send two frames → the first frame is held stable; s_ready drops at idx=3 of the second frame. Raise m_ready → the second frame loads in the consume cycle with m_valid continuously high, and no frame is lost.
- **Streaming:** 8 back-to-back frames with m_ready=1 and s_valid=1 → s_ready stays 1 throughout; 8 output frames arrive one every 4 cycles, all with correct data.
- **Short frame:** s_last on the 2nd sample, then a good frame 0, 0, 0, 255 → frame_err pulses once, err_count=1, and the only output is 8'b11_00_00_00.
- **Long frame:** 6 samples with s_last on the 6th, then a good frame → frame 1 is emitted, err_count=1, samples 5 and 6 are discarded, and the following good frame is emitted correctly.
- **Reset mid-frame:** assert rst after 2 samples → m_valid=0 and err_count=0. The next 4-sample frame is emitted correctly.
- **err_count saturation:** 300 short frames → err_count=255.
